// File: rtl/cmul_pkg.sv
// Shared widths, complex sample type and product-sum width helper for cmul_pipe.
package cmul_pkg;

  localparam int CMUL_DATA_W = 16;
  localparam int CMUL_COEF_W = 16;

  typedef struct packed {
    logic signed [CMUL_DATA_W-1:0] re;
    logic signed [CMUL_DATA_W-1:0] im;
  } cmul_cplx_t;

  // Two full-width products summed need one extra bit of headroom.
  function automatic int cmul_sum_w(input int data_w, input int coef_w);
    return data_w + coef_w + 1;
  endfunction

endpackage

// File: rtl/cmul_rndsat.sv
// Combinational round-half-up, Q1.(COEF_W-1) rescale and clamp/wrap of one product sum.
// Saturation is built only when CMUL_SAT_EN is defined; otherwise the result wraps and ovf=0.
module cmul_rndsat
  import cmul_pkg::*;
#(
  parameter int DATA_W = CMUL_DATA_W,
  parameter int COEF_W = CMUL_COEF_W,
  parameter int SUM_W  = cmul_sum_w(DATA_W, COEF_W)
) (
  input  logic signed [SUM_W-1:0]  sum,
  output logic        [DATA_W-1:0] y,
  output logic                     ovf
);

  localparam int EXT_W = SUM_W + 1;
  localparam int RND_W = EXT_W - (COEF_W - 1);

  logic signed [EXT_W-1:0] biased;
  logic        [RND_W-1:0] rnd;

  assign biased = EXT_W'(sum) + (EXT_W'(1) <<< (COEF_W - 2));
  // Taking the upper bits of the signed value is the arithmetic right shift.
  assign rnd = biased[EXT_W-1:COEF_W-1];

`ifdef CMUL_SAT_EN
  logic [RND_W-DATA_W:0] top_bits;
  logic                  unused_lsb;

  // In range only when every bit from the result sign upward agrees.
  assign top_bits   = rnd[RND_W-1:DATA_W-1];
  assign ovf        = !((&top_bits) || !(|top_bits));
  assign unused_lsb = ^biased[COEF_W-2:0];

  always_comb begin
    y = rnd[DATA_W-1:0];
    if (ovf) begin
      y = rnd[RND_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  logic unused_bits;

  assign y           = rnd[DATA_W-1:0];
  assign ovf         = 1'b0;
  assign unused_bits = ^{biased[COEF_W-2:0], rnd[RND_W-1:DATA_W]};
`endif

endmodule

// File: rtl/cmul_pipe.sv
// Three-stage complex multiplier y = a*w, result 3 cycles after accept; one global stall
// enable (in_ready = !out_valid || out_ready) holds every stage. CMUL_SAT_EN enables saturation.
module cmul_pipe
  import cmul_pkg::*;
#(
  parameter int DATA_W = CMUL_DATA_W,
  parameter int COEF_W = CMUL_COEF_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [COEF_W-1:0] w_re,
  input  logic signed [COEF_W-1:0] w_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [DATA_W-1:0] y_re,
  output logic        [DATA_W-1:0] y_im,
  output logic                     ovf
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = cmul_sum_w(DATA_W, COEF_W);

  logic                     en;
  logic                     s1_vld;
  logic signed [DATA_W-1:0] s1_a_re, s1_a_im;
  logic signed [COEF_W-1:0] s1_w_re, s1_w_im;
  logic                     s2_vld;
  logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SUM_W-1:0]  sum_re, sum_im;
  logic        [DATA_W-1:0] rs_re, rs_im;
  logic                     rs_ovf_re, rs_ovf_im;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: operand capture. Data registers need no reset; only valids matter.
  always_ff @(posedge clk) begin
    if (!rst_n)  s1_vld <= 1'b0;
    else if (en) s1_vld <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s1_a_re <= a_re;
      s1_a_im <= a_im;
      s1_w_re <= w_re;
      s1_w_im <= w_im;
    end
  end

  // Stage 2: the four partial products at full precision.
  always_ff @(posedge clk) begin
    if (!rst_n)  s2_vld <= 1'b0;
    else if (en) s2_vld <= s1_vld;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      p_rr <= PROD_W'(s1_a_re) * PROD_W'(s1_w_re);
      p_ii <= PROD_W'(s1_a_im) * PROD_W'(s1_w_im);
      p_ri <= PROD_W'(s1_a_re) * PROD_W'(s1_w_im);
      p_ir <= PROD_W'(s1_a_im) * PROD_W'(s1_w_re);
    end
  end

  assign sum_re = SUM_W'(p_rr) - SUM_W'(p_ii);
  assign sum_im = SUM_W'(p_ri) + SUM_W'(p_ir);

  cmul_rndsat #(.DATA_W(DATA_W), .COEF_W(COEF_W), .SUM_W(SUM_W)) u_rs_re (
    .sum (sum_re),
    .y   (rs_re),
    .ovf (rs_ovf_re)
  );

  cmul_rndsat #(.DATA_W(DATA_W), .COEF_W(COEF_W), .SUM_W(SUM_W)) u_rs_im (
    .sum (sum_im),
    .y   (rs_im),
    .ovf (rs_ovf_im)
  );

  // Stage 3: output register, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y_re      <= '0;
      y_im      <= '0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= s2_vld;
      y_re      <= rs_re;
      y_im      <= rs_im;
      ovf       <= rs_ovf_re | rs_ovf_im;
    end
  end

endmodule

// File: doc/cmul_pipe.md
CMUL_PIPE -- requirements
Module: cmul_pipe

Interface
REQ-001 Parameter DATA_W, 16, width of signed two's-complement data operands and results.
REQ-002 Parameter COEF_W, 16, width of signed twiddle coefficients, format Q1.(COEF_W-1).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a_re, a_im  input  DATA_W each  complex data sample.
REQ-008 w_re, w_im  input  COEF_W each  complex twiddle.
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 y_re, y_im  output  DATA_W each  complex product, rounded and scaled.
REQ-012 ovf  output  1  saturation occurred on y_re or y_im of the current beat.

Function
REQ-013 The block computes y = a*w: y_re = a_re*w_re - a_im*w_im and y_im = a_re*w_im + a_im*w_re, all operands signed two's complement.
REQ-014 Each full-precision sum is DATA_W+COEF_W+1 bits.
REQ-015 Rounding adds 2^(COEF_W-2), then arithmetically shifts right by COEF_W-1 (round half up).
REQ-016 The pipeline has three register stages. S1 registers operands, S2 registers the four products, and S3 registers the round/saturate result into y_re, y_im, ovf and out_valid.
REQ-017 Latency is 3 cycles from the accepting in_valid&&in_ready edge to out_valid, with no stalls.
REQ-018 The block accepts one beat per cycle when out_ready is held high.
REQ-019 Stage enable en = !out_valid || out_ready. All stages and their valid bits advance only when en is high.
REQ-020 in_ready = en, a combinational function of out_valid and out_ready.
REQ-021 While out_valid=1 and out_ready=0, y_re, y_im and ovf hold stable and no beat is lost, duplicated or reordered.
REQ-022 Bubbles (in_valid=0) propagate as invalid stages. Data registers of invalid stages may update freely.
REQ-023 When accept and output occur in the same cycle, both take effect.

Reset
REQ-024 While rst_n=0 at a clock edge, all stage valid bits clear and out_valid=0, y_re=0, y_im=0, ovf=0 after that edge.
REQ-025 While rst_n=0, in_ready follows REQ-020 and evaluates to 1.
REQ-026 Beats in flight when reset is asserted mid-operation are discarded and never appear at the output.

Configuration
REQ-027 Macro CMUL_SAT_EN selects the overflow behaviour.
REQ-028 With CMUL_SAT_EN defined, a rounded result above 2^(DATA_W-1)-1 clamps to that value, a result below -2^(DATA_W-1) clamps to that value, and ovf=1 for that beat.
REQ-029 Without CMUL_SAT_EN, the result is truncated to its low DATA_W bits (wrap) and ovf is tied to 0.

Structure
REQ-030 A shared package cmul_pkg holds:
- the default width constants;
- a typedef for the complex sample {re, im};
- a function computing the product-sum width.
REQ-031 One sub-module, cmul_rndsat, implements the combinational round/shift/saturate for one component and is instantiated twice in S3.

Verification
REQ-032 Scaling: DATA_W=COEF_W=16, a=(0x4000,0), w=(0x4000,0) -> after 3 cycles y=(0x2000,0x0000), ovf=0.
REQ-033 Rounding: a=(1,0), w=(0x4000,0) -> y_re=1. Then a=(-1,0) with the same w -> y_re=0.
REQ-034 Overflow: a=(-32768,-32768), w=(-32768,-32768) gives y_re=0 in both builds.
- With CMUL_SAT_EN: y_im=0x7FFF, ovf=1.
- Without CMUL_SAT_EN: y_im=0x0000, ovf=0.
REQ-035 Backpressure:
- Stimulus: stream 10 random beats with out_ready toggled randomly, including a 5-cycle low hold.
- Response: outputs match a reference model in order, y is stable while stalled, and in_ready=0 whenever out_valid=1 and out_ready=0.
REQ-036 Reset mid-stream: drive 3 beats, then hold rst_n=0 for 1 cycle -> out_valid=0, y=(0,0), ovf=0 next cycle, and none of the 3 beats is ever output.
REQ-037 Throughput: with out_ready=1 and in_valid=1 for 8 cycles, 8 results appear on 8 consecutive cycles starting 3 cycles after the first accept.
